// File: rtl/bec_operand_loader.sv
// Operand feeder for the binary-Edwards scalar-multiplication core: assembles seven
// 163-bit operands from a 32-bit word stream, starts the core, and serves key bits LSB-first.
module bec_operand_loader #(
    parameter int WORD_W  = 32,
    parameter int FIELD_W = 163,
    parameter int WPO     = 6,
    parameter int N_OPS   = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD_W-1:0]  in_data,
    input  logic               flush,
    input  logic               start,
    output logic               core_enable,
    input  logic               core_done,
    input  logic               next_key,
    output logic [FIELD_W-1:0] w1,
    output logic [FIELD_W-1:0] z1,
    output logic [FIELD_W-1:0] w2,
    output logic [FIELD_W-1:0] z2,
    output logic [FIELD_W-1:0] inv_w0,
    output logic [FIELD_W-1:0] d,
    output logic               ki,
    output logic               loaded,
    output logic               busy,
    output logic               err
);
    localparam int LAST_W = FIELD_W - WORD_W * (WPO - 1);
    localparam int WC_W   = $clog2(WPO);
    localparam int OP_W   = $clog2(N_OPS);
    localparam int KC_W   = $clog2(FIELD_W + 1);
    localparam int POS_W  = $clog2(WORD_W * WPO);

    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(WPO - 1);
    localparam logic [OP_W-1:0] LAST_OP   = OP_W'(N_OPS - 1);
    localparam logic [KC_W-1:0] KEY_BITS  = KC_W'(FIELD_W);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOADED = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t             state_reg;
    logic [WC_W-1:0]    word_cnt_reg;
    logic [OP_W-1:0]    op_idx_reg;
    logic [KC_W-1:0]    key_cnt_reg;
    logic [FIELD_W-1:0] key_reg;
    logic               err_reg;
    logic               loaded_reg;
    logic               busy_reg;
    logic               core_enable_reg;

    logic               accept;
    logic               last_word;
    logic               first_word;
    logic               word_overflow;
    logic [POS_W-1:0]   bit_pos;
    logic [FIELD_W-1:0] word_field;
    logic [FIELD_W-1:0] word_mask;

    // Flush takes priority over an incoming word, so the word is not taken at all.
    assign accept        = (state_reg == IDLE) && in_valid && !flush;
    assign last_word     = (word_cnt_reg == LAST_WORD);
    assign first_word    = (word_cnt_reg == '0) && (op_idx_reg == '0);
    assign word_overflow = last_word && (|in_data[WORD_W-1:LAST_W]);

    // Place the word at its bit position; the shift naturally drops the bits above the field.
    always_comb begin
        bit_pos    = POS_W'(word_cnt_reg) * POS_W'(WORD_W);
        word_field = {{(FIELD_W - WORD_W){1'b0}}, in_data} << bit_pos;
        word_mask  = {{(FIELD_W - WORD_W){1'b0}}, {WORD_W{1'b1}}} << bit_pos;
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_OPS - 1; gi++) begin : g_op
            logic [FIELD_W-1:0] op_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    op_reg <= '0;
                end else if (accept && (op_idx_reg == OP_W'(gi))) begin
                    op_reg <= (op_reg & ~word_mask) | word_field;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            word_cnt_reg    <= '0;
            op_idx_reg      <= '0;
            key_cnt_reg     <= '0;
            key_reg         <= '0;
            err_reg         <= 1'b0;
            loaded_reg      <= 1'b0;
            busy_reg        <= 1'b0;
            core_enable_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (flush) begin
                        word_cnt_reg <= '0;
                        op_idx_reg   <= '0;
                    end else if (in_valid) begin
                        if (op_idx_reg == LAST_OP) begin
                            key_reg <= (key_reg & ~word_mask) | word_field;
                        end
                        if (first_word) begin
                            err_reg <= 1'b0;
                        end
                        if (word_overflow) begin
                            err_reg <= 1'b1;
                        end
                        if (last_word) begin
                            word_cnt_reg <= '0;
                            if (op_idx_reg == LAST_OP) begin
                                op_idx_reg <= '0;
                                state_reg  <= LOADED;
                                loaded_reg <= 1'b1;
                            end else begin
                                op_idx_reg <= op_idx_reg + 1'b1;
                            end
                        end else begin
                            word_cnt_reg <= word_cnt_reg + 1'b1;
                        end
                    end
                end
                LOADED: begin
                    if (start) begin
                        state_reg       <= RUN;
                        busy_reg        <= 1'b1;
                        core_enable_reg <= 1'b1;
                    end
                end
                RUN: begin
                    if (next_key) begin
                        // Once every key bit has been consumed a further request is an underflow.
                        if (key_cnt_reg == KEY_BITS) begin
                            err_reg <= 1'b1;
                        end else begin
                            key_reg     <= key_reg >> 1;
                            key_cnt_reg <= key_cnt_reg + 1'b1;
                        end
                    end
                    if (core_done) begin
                        state_reg       <= IDLE;
                        word_cnt_reg    <= '0;
                        op_idx_reg      <= '0;
                        key_cnt_reg     <= '0;
                        loaded_reg      <= 1'b0;
                        busy_reg        <= 1'b0;
                        core_enable_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (state_reg == IDLE);
    assign core_enable = core_enable_reg;
    assign loaded      = loaded_reg;
    assign busy        = busy_reg;
    assign err         = err_reg;
    assign ki          = key_reg[0];

    assign w1     = g_op[0].op_reg;
    assign z1     = g_op[1].op_reg;
    assign w2     = g_op[2].op_reg;
    assign z2     = g_op[3].op_reg;
    assign inv_w0 = g_op[4].op_reg;
    assign d      = g_op[5].op_reg;

endmodule

// File: tb/tb_bec_operand_loader.sv
// Directed/random bench for bec_operand_loader; expected operands come from the
// word list via plain arithmetic, expected key bits from indexing the loaded key.
module tb_bec_operand_loader;
    localparam int WORD_W  = 32;
    localparam int FIELD_W = 163;
    localparam int WPO     = 6;
    localparam int N_OPS   = 7;
    localparam int N_WORDS = WPO * N_OPS;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [WORD_W-1:0]  in_data;
    logic               flush;
    logic               start;
    logic               core_enable;
    logic               core_done;
    logic               next_key;
    logic [FIELD_W-1:0] w1, z1, w2, z2, inv_w0, d;
    logic               ki;
    logic               loaded;
    logic               busy;
    logic               err;

    int errors = 0;
    int checks = 0;
    logic [WORD_W-1:0] words [N_WORDS];

    always #5 clk = ~clk;

    bec_operand_loader dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .flush       (flush),
        .start       (start),
        .core_enable (core_enable),
        .core_done   (core_done),
        .next_key    (next_key),
        .w1          (w1),
        .z1          (z1),
        .w2          (w2),
        .z2          (z2),
        .inv_w0      (inv_w0),
        .d           (d),
        .ki          (ki),
        .loaded      (loaded),
        .busy        (busy),
        .err         (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [FIELD_W-1:0] obs, input logic [FIELD_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Operand i is the little-endian concatenation of its words, truncated to the field.
    function automatic logic [FIELD_W-1:0] ref_op(input int i);
        logic [WORD_W*WPO-1:0] acc;
        acc = '0;
        for (int k = 0; k < WPO; k++)
            acc = acc | ({{(WORD_W*(WPO-1)){1'b0}}, words[i*WPO+k]} << (WORD_W * k));
        return acc[FIELD_W-1:0];
    endfunction

    function automatic logic ref_key_bit(input int n);
        logic [FIELD_W-1:0] key;
        key = ref_op(N_OPS - 1);
        return (n < FIELD_W) ? key[n] : 1'b0;
    endfunction

    function automatic logic [FIELD_W-1:0] dut_op(input int i);
        case (i)
            0: return w1;
            1: return z1;
            2: return w2;
            3: return z2;
            4: return inv_w0;
            default: return d;
        endcase
    endfunction

    task automatic check_ops(input string tag);
        for (int i = 0; i < N_OPS - 1; i++)
            check($sformatf("%s_op%0d", tag, i), dut_op(i), ref_op(i));
        check1({tag, "_ki"}, ki, ref_key_bit(0));
    endtask

    task automatic random_words();
        for (int n = 0; n < N_WORDS; n++)
            words[n] = ((n % WPO) == WPO - 1) ? ($urandom & 32'h7) : $urandom;
    endtask

    task automatic load_all(input bit toggle, input int first);
        for (int n = first; n < N_WORDS; n++) begin
            if (toggle) begin
                in_valid = 1'b0;
                tick();
                check1($sformatf("ready_gap%0d", n), in_ready, 1'b1);
            end
            in_valid = 1'b1;
            in_data  = words[n];
            if (n == N_WORDS - 1) check1("loaded_pre", loaded, 1'b0);
            tick();
        end
        in_valid = 1'b0;
        check1("loaded_post", loaded, 1'b1);
        check1("ready_loaded", in_ready, 1'b0);
    endtask

    task automatic start_core(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        check1({tag, "_en"}, core_enable, 1'b1);
        check1({tag, "_busy"}, busy, 1'b1);
    endtask

    task automatic finish_core(input string tag);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check1({tag, "_en_low"}, core_enable, 1'b0);
        check1({tag, "_busy_low"}, busy, 1'b0);
        check1({tag, "_loaded_low"}, loaded, 1'b0);
        check1({tag, "_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        int nk;
        logic [FIELD_W-1:0] w1_exp;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0;
        start = 1'b0; core_done = 1'b0; next_key = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check1("rst_ready", in_ready, 1'b1);
        check1("rst_ki", ki, 1'b0);
        check1("rst_loaded", loaded, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_err", err, 1'b0);
        check1("rst_en", core_enable, 1'b0);
        check("rst_w1", w1, '0);

        // Directed stream: w1 = {101, zeros, 1}, everything else all ones.
        for (int i = 0; i < N_OPS; i++)
            for (int k = 0; k < WPO; k++)
                words[i*WPO+k] = (i == 0) ? ((k == 0) ? 32'h1 : (k == WPO-1) ? 32'h5 : 32'h0)
                                          : ((k == WPO-1) ? 32'h7 : 32'hFFFF_FFFF);
        load_all(1'b0, 0);
        w1_exp = {3'b101, 159'b0, 1'b1};
        check("t1_w1_const", w1, w1_exp);
        check_ops("t1");
        check1("t1_err", err, 1'b0);
        start_core("t1");
        check1("t1_ready_run", in_ready, 1'b0);
        finish_core("t1");

        // Same stream with gaps in in_valid.
        load_all(1'b1, 0);
        check_ops("t2");
        check1("t2_err", err, 1'b0);
        start_core("t2");
        finish_core("t2");

        // Oversized top word of d flags err; the next load's first word clears it.
        random_words();
        words[5*WPO+WPO-1] = 32'h0000_0009;
        load_all(1'b0, 0);
        check1("t3_err_set", err, 1'b1);
        check("t3_d", d, ref_op(5));
        check("t3_d_top", {160'b0, d[162:160]}, {160'b0, 3'b001});
        start_core("t3");
        finish_core("t3");
        check1("t3_err_sticky", err, 1'b1);
        random_words();
        in_valid = 1'b1; in_data = words[0];
        tick();
        check1("t3_err_cleared", err, 1'b0);
        load_all(1'b0, 1);
        check_ops("t3b");
        start_core("t3b");
        finish_core("t3b");

        // Key = 5, three next_key pulses.
        random_words();
        words[36] = 32'h5;
        for (int k = 1; k < WPO; k++) words[36+k] = '0;
        load_all(1'b0, 0);
        check1("t4_ki0", ki, 1'b1);
        start_core("t4");
        for (int n = 1; n <= 3; n++) begin
            next_key = 1'b1;
            tick();
            next_key = 1'b0;
            check1($sformatf("t4_ki%0d", n), ki, ref_key_bit(n));
        end
        finish_core("t4");

        // 20 words, then a flush with a valid word, then a full load.
        for (int n = 0; n < 20; n++) begin
            in_valid = 1'b1; in_data = $urandom;
            tick();
        end
        flush = 1'b1; in_valid = 1'b1; in_data = $urandom;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check1("t5_ready", in_ready, 1'b1);
        check1("t5_loaded", loaded, 1'b0);
        random_words();
        load_all(1'b0, 0);
        check_ops("t5");
        check1("t5_err", err, 1'b0);

        // Walk every key bit past the end; the 164th request underflows.
        start_core("t6");
        for (int n = 1; n <= FIELD_W + 2; n++) begin
            next_key = 1'b1;
            tick();
            next_key = 1'b0;
            check1($sformatf("t6_ki%0d", n), ki, ref_key_bit(n));
            check1($sformatf("t6_err%0d", n), err, (n > FIELD_W) ? 1'b1 : 1'b0);
        end
        finish_core("t6");

        // next_key together with core_done is still honoured.
        random_words();
        load_all(1'b0, 0);
        start_core("t7");
        nk = $urandom_range(0, 10);
        for (int n = 0; n < nk; n++) begin
            next_key = 1'b1;
            tick();
            next_key = 1'b0;
        end
        next_key = 1'b1;
        finish_core("t7");
        next_key = 1'b0;
        check1("t7_ki", ki, ref_key_bit(nk + 1));

        // start is ignored in IDLE, including mid-load.
        start = 1'b1;
        tick();
        start = 1'b0;
        check1("t8_en", core_enable, 1'b0);
        check1("t8_busy", busy, 1'b0);
        check1("t8_ready", in_ready, 1'b1);
        random_words();
        for (int n = 0; n < 10; n++) begin
            in_valid = 1'b1; in_data = words[n];
            tick();
        end
        in_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check1("t8_mid_en", core_enable, 1'b0);
        check1("t8_mid_ready", in_ready, 1'b1);
        load_all(1'b0, 10);
        check_ops("t8");

        // Reset while running.
        start_core("t9");
        next_key = 1'b1;
        tick();
        next_key = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check1("t9_en", core_enable, 1'b0);
        check1("t9_busy", busy, 1'b0);
        check1("t9_loaded", loaded, 1'b0);
        check1("t9_ready", in_ready, 1'b1);
        check1("t9_ki", ki, 1'b0);
        check1("t9_err", err, 1'b0);
        for (int i = 0; i < N_OPS - 1; i++)
            check($sformatf("t9_op%0d", i), dut_op(i), '0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check1("t9_start_idle", core_enable, 1'b0);
        random_words();
        load_all(1'b0, 0);
        check_ops("t9b");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bec_operand_loader.md
Name: bec_operand_loader

Overview:
- Upstream feeder for the sm_bec_v3 binary-Edwards scalar-multiplication core (GF(2^163)).
- Accepts a 32-bit word stream on a valid/ready handshake and assembles seven 163-bit operands: w1, z1, w2, z2, inv_w0, d, key.
- Holds the operands stable while the core runs, starts the core, and serves scalar key bits LSB-first on the core's next_key request.

Parameters:
- WORD_W, 32, input word width
- FIELD_W, 163, field element width
- WPO, 6, words per operand (ceil(FIELD_W/WORD_W))
- N_OPS, 7, number of operands

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input word valid
- in_ready  out  1  loader can accept a word
- in_data  in  WORD_W  input word
- flush  in  1  discard a partial load; honoured only in IDLE
- start  in  1  request core run; honoured only in LOADED
- core_enable  out  1  drives the core's enable input
- core_done  in  1  core done
- next_key  in  1  core request to advance the key bit
- w1, z1, w2, z2, inv_w0, d  out  FIELD_W each  operand registers
- ki  out  1  current key bit, equal to key_reg[0]
- loaded  out  1  all operands received
- busy  out  1  core running
- err  out  1  sticky format/underflow error; cleared by rst or by the first accepted word of a new load

Behaviour:
- Reset: every operand register and key_reg = 0; word_cnt = 0, op_idx = 0, key_cnt = 0, err = 0; state = IDLE; core_enable = 0, loaded = 0, busy = 0. Outputs: in_ready = 1, ki = 0.
- A word is accepted when in_valid && in_ready in the same cycle.
- Load order: operand index 0..6 = w1, z1, w2, z2, inv_w0, d, key.
  - Within an operand, words go least-significant first: word k fills bits [32k+31:32k] for k = 0..4.
  - Word 5 fills bits [162:160] from in_data[2:0].
  - If in_data[31:3] != 0 on word 5, set err. The word is still accepted and the upper bits are dropped.
- Counters: word_cnt wraps 5->0 and op_idx increments on that wrap. The accept that completes op_idx = 6, word 5 (the 42nd word) moves the state to LOADED.
- States:
  - IDLE: in_ready = 1. Words are stored as they are accepted.
    - flush = 1 clears word_cnt and op_idx; operand registers keep their contents. flush wins over a same-cycle accept, and that word is dropped.
    - The 42nd accept moves to LOADED on the next edge.
  - LOADED: in_ready = 0, loaded = 1. start = 1 moves to RUN next cycle, with core_enable = 1 and busy = 1 from that cycle.
  - RUN: in_ready = 0, core_enable = 1. Operand outputs are frozen.
    - next_key = 1: key_reg shifts right by 1 (zero fill) and key_cnt increments; ki reflects the new LSB the next cycle.
    - next_key with key_cnt == FIELD_W: set err, no shift; ki stays 0.
    - core_done = 1: move to IDLE next cycle (core_enable = 0, busy = 0, loaded = 0); clear word_cnt, op_idx and key_cnt. A next_key in the same cycle is still honoured.
- start outside LOADED, and flush outside IDLE, are ignored.
- rst mid-load or mid-run restores the reset state immediately at the edge; core_enable drops the following cycle.
- in_ready is a pure function of state (no combinational path from in_valid).
- Latency:
  - 42nd accept -> loaded high 1 cycle later.
  - start -> core_enable high 1 cycle later.
  - core_done -> core_enable low 1 cycle later.

Test Plan:
- Stream 42 words with w1 words = 0x00000001,0,0,0,0,0x5 and remaining operands all 0xFFFFFFFF except word-5 = 0x7 -> w1 = {3'b101,159'b0,1'b1}, other operands = all ones; loaded rises 1 cycle after the 42nd accept; err = 0.
- Same stream with in_valid toggled every other cycle -> identical final registers; in_ready stays 1 until the 42nd accept, then 0.
- Word 5 of d = 0x00000009 -> err = 1, d[162:160] = 3'b001. The next load's first accepted word clears err.
- Load with key = 163'h5; start; pulse next_key 3 times -> ki sequence 1,0,1,0. Then core_done -> core_enable = 0 next cycle, state IDLE, in_ready = 1.
- Feed 20 words, pulse flush with in_valid = 1 -> that word dropped; a following full 42-word load produces the correct operands.
- Assert rst while in RUN -> all outputs return to reset values next cycle; start asserted during IDLE has no effect.
